seg_scan_mux: RTL
=================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised time-multiplexed 7-segment driver: scans NUM_DIGITS common-anode digits
//  from per-digit hex nibbles, with inter-digit ghost blanking and tear-free frame capture.
//  Sits between the datapath (counters/BCD) and the board seg/an pins.
// PARAMETERS
//  NUM_DIGITS  4            digits scanned (2..8)
//  CLK_HZ      100_000_000  clk frequency
//  REFRESH_HZ  1000         full-frame refresh rate
//  GAP_CYC     16           blank cycles at start of each digit slot (anti-ghosting)
//  localparam SLOT = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) clocks/slot; SLOT > GAP_CYC+1 required
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             synchronous reset, active low
//  digits       in   4*NUM_DIGITS  hex nibble per digit, digit 0 = bits[3:0]
//  dp_in        in   NUM_DIGITS    decimal point per digit, 1 = lit
//  blank_in     in   NUM_DIGITS    1 = digit dark
//  bright       in   3             duty 0..7 (present only with SEG_DIM_EN)
//  seg_cat      out  7             {g,f,e,d,c,b,a}, active low
//  seg_dp       out  1             decimal point, active low
//  seg_an       out  NUM_DIGITS    anode enables, active low
//  frame_strobe out  1             1-cycle pulse when inputs are captured
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. On rst_n=0 at a clk edge: seg_an all 1,
//    seg_cat 7'h7F, seg_dp 1, frame_strobe 0, slot_cnt 0, idx 0, state GAP, snapshots 0.
//  - All outputs registered. slot_cnt counts 0..SLOT-1 and wraps; idx advances by one at wrap.
//  - FSM: GAP (slot_cnt < GAP_CYC): seg_an all 1, seg_cat 7'h7F, seg_dp 1.
//         DRIVE (GAP_CYC <= slot_cnt < SLOT): seg_an[idx]=0 unless blank_s[idx]; seg_cat =
//         decode(digits_s[idx]); seg_dp = ~dp_s[idx]. GAP->DRIVE at slot_cnt==GAP_CYC-1;
//         DRIVE->GAP at slot_cnt==SLOT-1.
//  - idx wraps NUM_DIGITS-1 -> 0. In that wrap cycle digits/dp_in/blank_in (and bright)
//    are latched into *_s snapshots and frame_strobe pulses for one cycle.
//  - Input changes are visible at the first DRIVE after the next frame boundary; mid-frame
//    changes never alter the current frame (no tearing).
//  - First frame after reset: snapshots are 0, so all digits show '0' until the first capture;
//    the first capture occurs at the first idx wrap (cycle NUM_DIGITS*SLOT-1 after reset release).
//  - Decode, active low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46
//    d=21 E=06 F=0E (hex).
//  - No two anodes are ever low simultaneously; at most one anode is low in any cycle.
//  - Reset asserted mid-slot: next cycle is the reset state; the scan restarts at idx 0, GAP.
// CONFIGURATION
//  - SEG_DIM_EN defined: bright port exists. A free-running 3-bit pwm_cnt runs during DRIVE.
//    The anode is enabled only while pwm_cnt <= bright_s. bright_s is latched at the frame
//    boundary; bright=7 gives full duty and bright=0 gives 1/8 duty.
//    The cathodes stay driven throughout DRIVE; only the anode is gated.
//  - SEG_DIM_EN undefined: no bright port, no pwm logic; full duty in DRIVE.
// STRUCTURE
//  - seg_pkg: hex->segment localparam table, SEG_OFF=7'h7F, clog2 helper for idx/slot widths.
//  - Sub-module seg_hex_decode: combinational 4-bit -> 7-bit active-low decoder.
//    It is instantiated once, on the muxed snapshot nibble.
//  - Top holds prescaler, idx counter, FSM, snapshot regs, pwm counter.
// TESTING
//  Bench params: CLK_HZ=400, REFRESH_HZ=10, NUM_DIGITS=4, GAP_CYC=2 -> SLOT=10.
//  1 Reset: hold rst_n=0 for 3 clks -> seg_an=4'hF, seg_cat=7'h7F, seg_dp=1, frame_strobe=0.
//  2 Scan: digits=16'h1234, dp_in=4'b0010, blank_in=0; in 2nd frame digit0 slot cycles 2..9:
//    seg_an=4'b1110, seg_cat=7'h19 ('4'). Digit1 slot: seg_an=4'b1101, seg_cat=7'h30 ('3'),
//    seg_dp=0. Slot cycles 0..1 of every slot: seg_an=4'hF.
//  3 Tear-free: change digits to 16'hABCD mid-frame -> current frame still shows 1234;
//    the next frame shows D,C,b,A.
//  4 frame_strobe: exactly one pulse every 40 clks; the pulse coincides with the idx 3->0 wrap.
//  5 Blank/overlap: blank_in=4'b0100 -> seg_an[2] never 0. Assertion over 10k clks:
//    popcount(~seg_an) <= 1 every cycle.
//  6 Reset mid-DRIVE (idx=2, slot_cnt=5) -> next clk reset state; after release, idx 0 GAP.
//    With SEG_DIM_EN and bright=3: anode low 4 of each 8 DRIVE cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seg_scan_mux 7-segment scanner.
// Holds the hex-to-segment table, the blank pattern and a width helper.
package seg_pkg;

   typedef enum logic {
      ST_GAP   = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << bits) < 64'(value)) bits = bits + 1;
      end
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit nibble to active-low 7-segment pattern.
// Pure table lookup so the top can place it after its digit mux.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with ghost blanking and
// frame-boundary input capture. Define SEG_DIM_EN to add the bright PWM input.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int GAP_CYC    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_DIM_EN
   input  logic [2:0]              bright,
`endif
   output logic [6:0]              seg_cat,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   seg_an,
   output logic                    frame_strobe
);

   localparam int SLOT   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int SLOT_W = clog2_min1(SLOT);
   localparam int IDX_W  = clog2_min1(NUM_DIGITS);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 1);
   localparam logic [SLOT_W-1:0] GAP_LAST  = SLOT_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   scan_state_t             state_q, state_d;
   logic                    slot_last, idx_last, frame_wrap;

   logic [4*NUM_DIGITS-1:0] digits_s_q, digits_s_d;
   logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
   logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;

   logic [6:0]              seg_cat_q, seg_cat_d;
   logic                    seg_dp_q, seg_dp_d;
   logic [NUM_DIGITS-1:0]   seg_an_q, seg_an_d;
   logic                    frame_strobe_q, frame_strobe_d;

   logic [3:0]              nibble_mux;
   logic [6:0]              dec_seg;
   logic                    pwm_ok;

`ifdef SEG_DIM_EN
   logic [2:0]              pwm_q, pwm_d;
   logic [2:0]              bright_s_q, bright_s_d;
`endif

   // Prescaler, digit index and GAP/DRIVE sequencing.
   always_comb begin
      slot_last  = (slot_cnt_q == SLOT_LAST);
      idx_last   = (idx_q == IDX_LAST);
      frame_wrap = slot_last && idx_last;

      slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (slot_last) begin
         idx_d = idx_last ? '0 : idx_q + 1'b1;
      end

      state_d = state_q;
      unique case (state_q)
         ST_GAP:   if (slot_cnt_q == GAP_LAST) state_d = ST_DRIVE;
         ST_DRIVE: if (slot_last) state_d = ST_GAP;
         default:  state_d = ST_GAP;
      endcase
   end

   // Snapshots only move at the frame boundary, so a frame never tears.
   always_comb begin
      digits_s_d = digits_s_q;
      dp_s_d     = dp_s_q;
      blank_s_d  = blank_s_q;
      if (frame_wrap) begin
         digits_s_d = digits;
         dp_s_d     = dp_in;
         blank_s_d  = blank_in;
      end
   end

`ifdef SEG_DIM_EN
   always_comb begin
      bright_s_d = frame_wrap ? bright : bright_s_q;
      pwm_d      = (state_d == ST_DRIVE) ? pwm_q + 3'd1 : pwm_q;
      pwm_ok     = (pwm_d <= bright_s_q);
   end
`else
   assign pwm_ok = 1'b1;
`endif

   assign nibble_mux = digits_s_q[4*int'(idx_d) +: 4];

   seg_hex_decode u_decode (
      .nibble_i (nibble_mux),
      .seg_o    (dec_seg)
   );

   // Outputs are computed from next-state so the registered pins line up with slot_cnt.
   always_comb begin
      seg_an_d       = '1;
      seg_cat_d      = SEG_OFF;
      seg_dp_d       = 1'b1;
      frame_strobe_d = (idx_d == IDX_LAST) && (slot_cnt_d == SLOT_LAST);
      if (state_d == ST_DRIVE) begin
         seg_cat_d = dec_seg;
         seg_dp_d  = ~dp_s_q[idx_d];
         if (!blank_s_q[idx_d] && pwm_ok) begin
            seg_an_d[idx_d] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_cnt_q     <= '0;
         idx_q          <= '0;
         state_q        <= ST_GAP;
         digits_s_q     <= '0;
         dp_s_q         <= '0;
         blank_s_q      <= '0;
         seg_cat_q      <= SEG_OFF;
         seg_dp_q       <= 1'b1;
         seg_an_q       <= '1;
         frame_strobe_q <= 1'b0;
`ifdef SEG_DIM_EN
         pwm_q          <= '0;
         bright_s_q     <= '0;
`endif
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         idx_q          <= idx_d;
         state_q        <= state_d;
         digits_s_q     <= digits_s_d;
         dp_s_q         <= dp_s_d;
         blank_s_q      <= blank_s_d;
         seg_cat_q      <= seg_cat_d;
         seg_dp_q       <= seg_dp_d;
         seg_an_q       <= seg_an_d;
         frame_strobe_q <= frame_strobe_d;
`ifdef SEG_DIM_EN
         pwm_q          <= pwm_d;
         bright_s_q     <= bright_s_d;
`endif
      end
   end

   assign seg_cat      = seg_cat_q;
   assign seg_dp       = seg_dp_q;
   assign seg_an       = seg_an_q;
   assign frame_strobe = frame_strobe_q;

endmodule
